// File: rtl/mem_slot_arbiter_if.sv
// mem_slot_arbiter_if: bundles the CPU pins, the secondary-master handshake
// and the RAM port that meet at mem_slot_arbiter.
//   slave  : the arbiter's view (consumes CPU/DMA requests and RAM read data,
//            drives CPU read data, DMA ack/data and the RAM address/write port)
//   master : the surrounding system (CPU, DMA engine, RAM array)
// Optional: MEM_SLOT_ARBITER_STALL_EN adds the dma_hog request qualifier.
interface mem_slot_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  // CPU side
  logic [ADDR_W-1:0] cpu_a;
  logic [DATA_W-1:0] cpu_o;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_i;
  // Secondary master side
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_a;
  logic [DATA_W-1:0] dma_wd;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rd;
`ifdef MEM_SLOT_ARBITER_STALL_EN
  logic              dma_hog;
`endif
  // RAM side
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_o;
  logic              mem_we;
  logic [DATA_W-1:0] mem_i;

  modport slave (
`ifdef MEM_SLOT_ARBITER_STALL_EN
    input  dma_hog,
`endif
    input  cpu_a, cpu_o, cpu_we,
    output cpu_i,
    input  dma_req, dma_we, dma_a, dma_wd,
    output dma_ack, dma_rd,
    output mem_a, mem_o, mem_we,
    input  mem_i
  );

  modport master (
`ifdef MEM_SLOT_ARBITER_STALL_EN
    output dma_hog,
`endif
    output cpu_a, cpu_o, cpu_we,
    input  cpu_i,
    output dma_req, dma_we, dma_a, dma_wd,
    input  dma_ack, dma_rd,
    input  mem_a, mem_o, mem_we,
    output mem_i
  );
endinterface

// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter: time-slot scheduler sharing one synchronous RAM between the
// kr580 CPU and a secondary master. A free-running 2-bit phase counter splits
// every four pin_clk cycles into:
//   ph0 CPU access, ph1 CPU read capture, ph2 DMA access, ph3 DMA ack.
// The CPU clock is derived from the phase (high in ph2/ph3), so the CPU and the
// secondary master never contend for the RAM.
//
// Ports:
//   pin_clk   system clock, also clocks the RAM
//   pin_rstn  asynchronous active-low reset
//   cpu_clk   divided CPU clock (pin_clk / 4)
//   bus       mem_slot_arbiter_if.slave: CPU pins, DMA handshake, RAM port
//
// Optional: define MEM_SLOT_ARBITER_STALL_EN to add dma_hog. While the secondary
// master hogs, ph0 is handed to it as well and the CPU sees no clock edge.
module mem_slot_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              pin_clk,
  input  logic              pin_rstn,
  output logic              cpu_clk,
  mem_slot_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    PhCpu    = 2'd0,
    PhCpuRd  = 2'd1,
    PhDma    = 2'd2,
    PhDmaAck = 2'd3
  } phase_e;

  phase_e            ph_q, ph_d;
  logic              cpu_clk_q, cpu_clk_d;
  logic [DATA_W-1:0] cpu_i_q, cpu_i_d;
  logic [DATA_W-1:0] dma_rd_q, dma_rd_d;
  logic              grant_q, grant_d;
  logic              ack_q, ack_d;
  logic              stall_q, stall_d;
  // Set when the ack in ph1 belongs to a stalled-slot read.
  logic              byp_q, byp_d;

  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_o;
  logic              mem_we;
  logic              stall_req;

`ifdef MEM_SLOT_ARBITER_STALL_EN
  // A request still high when the round closes is a fresh transfer the master
  // wants in the stolen ph0 slot.
  assign stall_req = bus.dma_hog & bus.dma_req;
`else
  assign stall_req = 1'b0;
`endif

  always_ff @(posedge pin_clk or negedge pin_rstn) begin
    if (!pin_rstn) begin
      ph_q      <= PhCpu;
      cpu_clk_q <= 1'b0;
      cpu_i_q   <= '0;
      dma_rd_q  <= '0;
      grant_q   <= 1'b0;
      ack_q     <= 1'b0;
      stall_q   <= 1'b0;
      byp_q     <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      cpu_clk_q <= cpu_clk_d;
      cpu_i_q   <= cpu_i_d;
      dma_rd_q  <= dma_rd_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      stall_q   <= stall_d;
      byp_q     <= byp_d;
    end
  end

  always_comb begin
    ph_d      = ph_q;
    cpu_clk_d = 1'b0;
    cpu_i_d   = cpu_i_q;
    dma_rd_d  = dma_rd_q;
    grant_d   = grant_q;
    ack_d     = 1'b0;
    stall_d   = stall_q;
    byp_d     = 1'b0;
    mem_a     = bus.cpu_a;
    mem_o     = bus.cpu_o;
    mem_we    = 1'b0;

    unique case (ph_q)
      PhCpu: begin
        ph_d = PhCpuRd;
        if (stall_q) begin
          // Stolen slot: live dma_req qualifies it so a master that dropped
          // its request after the last ack gets no phantom transfer.
          if (bus.dma_req) begin
            mem_a  = bus.dma_a;
            mem_o  = bus.dma_wd;
            mem_we = bus.dma_we;
            ack_d  = 1'b1;
            byp_d  = ~bus.dma_we;
          end
        end else begin
          mem_we = bus.cpu_we;
        end
      end

      PhCpuRd: begin
        ph_d      = PhDma;
        grant_d   = bus.dma_req;
        cpu_clk_d = ~stall_q;
        if (!stall_q) begin
          cpu_i_d = bus.mem_i;
        end
        // Early read of the DMA address so the data is registered by the end
        // of ph2 and dma_rd is already valid in the ack cycle.
        if (bus.dma_req) begin
          mem_a = bus.dma_a;
        end
        if (byp_q) begin
          dma_rd_d = bus.mem_i;
        end
      end

      PhDma: begin
        ph_d      = PhDmaAck;
        cpu_clk_d = ~stall_q;
        if (grant_q) begin
          mem_a  = bus.dma_a;
          mem_o  = bus.dma_wd;
          mem_we = bus.dma_we;
          ack_d  = 1'b1;
          if (!bus.dma_we) begin
            dma_rd_d = bus.mem_i;
          end
        end
      end

      PhDmaAck: begin
        ph_d    = PhCpu;
        grant_d = 1'b0;
        stall_d = stall_req;
      end

      default: begin
        ph_d = PhCpu;
      end
    endcase
  end

  assign cpu_clk     = cpu_clk_q;
  assign bus.cpu_i   = cpu_i_q;
  assign bus.dma_ack = ack_q;
  // Stalled reads are acked in ph1, the cycle the RAM's own output register
  // presents the data, so it is forwarded and then held in dma_rd_q.
  assign bus.dma_rd  = byp_q ? bus.mem_i : dma_rd_q;
  assign bus.mem_a   = mem_a;
  assign bus.mem_o   = mem_o;
  assign bus.mem_we  = mem_we & pin_rstn;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
module tb_mem_slot_arbiter;

  logic pin_clk = 1'b0;
  logic pin_rstn;
  logic cpu_clk;

  mem_slot_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_slot_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .pin_clk (pin_clk),
    .pin_rstn(pin_rstn),
    .cpu_clk (cpu_clk),
    .bus     (bus)
  );

  always #5 pin_clk = ~pin_clk;

  // Synchronous RAM model with a backdoor write port used only during reset.
  logic [7:0]  ram [0:65535];
  logic        bd_we;
  logic [15:0] bd_a;
  logic [7:0]  bd_d;

  always @(posedge pin_clk) begin
    if (bd_we) ram[bd_a] <= bd_d;
    else if (bus.mem_we) ram[bus.mem_a] <= bus.mem_o;
    bus.mem_i <= ram[bus.mem_a];
  end

  int n_checks = 0;
  int n_errors = 0;
  int ph = 0;
  int lat;
  logic got_ack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pin_clk);
    #1;
    ph = (ph + 1) % 4;
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    bd_a  = a;
    bd_d  = d;
    bd_we = 1'b1;
    @(posedge pin_clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge pin_clk);
    #1;
    pin_rstn = 1'b1;
    ph = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pin_rstn    = 1'b0;
    bd_we       = 1'b0;
    bd_a        = '0;
    bd_d        = '0;
    bus.cpu_a   = 16'h00aa;
    bus.cpu_o   = 8'h00;
    bus.cpu_we  = 1'b1;
    bus.dma_req = 1'b0;
    bus.dma_we  = 1'b0;
    bus.dma_a   = '0;
    bus.dma_wd  = '0;
`ifdef MEM_SLOT_ARBITER_STALL_EN
    bus.dma_hog = 1'b0;
`endif
    bd_write(16'h0000, 8'h3e);
    bd_write(16'h1234, 8'h5a);
    bd_write(16'h2222, 8'h77);
    bd_write(16'h8000, 8'h00);

    // Reset state: CPU bus selected, write blocked.
    check_eq("rst_mem_we", bus.mem_we, 0);
    check_eq("rst_mem_a", bus.mem_a, 16'h00aa);
    check_eq("rst_cpu_clk", cpu_clk, 0);
    check_eq("rst_cpu_i", bus.cpu_i, 0);
    check_eq("rst_dma_ack", bus.dma_ack, 0);
    check_eq("rst_dma_rd", bus.dma_rd, 0);
    bus.cpu_we = 1'b0;
    bus.cpu_a  = 16'h0000;

    // 1: clock pattern and first CPU read.
    release_reset();
    for (int i = 0; i < 8; i++) begin
      check_eq("t1_cpu_clk", cpu_clk, (ph >= 2) ? 1 : 0);
      check_eq("t1_ack", bus.dma_ack, 0);
      if (ph == 2) check_eq("t1_cpu_i", bus.cpu_i, 8'h3e);
      tick();
    end

    // 2: CPU write only in ph0.
    bus.cpu_a  = 16'h8000;
    bus.cpu_o  = 8'ha5;
    bus.cpu_we = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_mem_we", bus.mem_we, (ph == 0) ? 1 : 0);
      if (ph == 0) begin
        check_eq("t2_mem_a", bus.mem_a, 16'h8000);
        check_eq("t2_mem_o", bus.mem_o, 8'ha5);
      end
      tick();
    end
    bus.cpu_we = 1'b0;
    check_eq("t2_ram8000", ram[16'h8000], 8'ha5);

    // 3: DMA read raised in ph0.
    bus.cpu_a   = 16'h0000;
    bus.dma_req = 1'b1;
    bus.dma_we  = 1'b0;
    bus.dma_a   = 16'h1234;
    #1;
    check_eq("t3_ack_ph0", bus.dma_ack, 0);
    tick();
    check_eq("t3_ack_ph1", bus.dma_ack, 0);
    check_eq("t3_we_ph1", bus.mem_we, 0);
    tick();
    check_eq("t3_mem_a_ph2", bus.mem_a, 16'h1234);
    check_eq("t3_we_ph2", bus.mem_we, 0);
    check_eq("t3_cpu_clk_ph2", cpu_clk, 1);
    check_eq("t3_cpu_i_ph2", bus.cpu_i, 8'h3e);
    tick();
    check_eq("t3_ack_ph3", bus.dma_ack, 1);
    check_eq("t3_rd_ph3", bus.dma_rd, 8'h5a);
    check_eq("t3_cpu_clk_ph3", cpu_clk, 1);
    bus.dma_req = 1'b0;
    tick();
    check_eq("t3_ack_ph0b", bus.dma_ack, 0);
    check_eq("t3_rd_held", bus.dma_rd, 8'h5a);
    check_eq("t3_cpu_clk_ph0", cpu_clk, 0);

    // 4: request raised in ph2 misses this round; then back-to-back transfers.
    tick();
    tick();
    bus.dma_req = 1'b1;
    bus.dma_a   = 16'h2222;
    #1;
    check_eq("t4_mem_a_nogrant", bus.mem_a, 16'h0000);
    check_eq("t4_we_nogrant", bus.mem_we, 0);
    lat = 0;
    got_ack = 1'b0;
    while (!got_ack && lat < 12) begin
      tick();
      lat++;
      if (bus.dma_ack) got_ack = 1'b1;
    end
    check_eq("t4_latency", lat, 5);
    check_eq("t4_rd1", bus.dma_rd, 8'h77);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("t4_ack_spacing", bus.dma_ack, (ph == 3) ? 1 : 0);
      if (ph == 3) check_eq("t4_rd", bus.dma_rd, 8'h77);
      if (i == 7) bus.dma_req = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t4_ack_idle", bus.dma_ack, 0);
    end
    tick();

    // 5: CPU and DMA write the same address in one round.
    bus.cpu_a   = 16'h4000;
    bus.cpu_o   = 8'h11;
    bus.cpu_we  = 1'b1;
    bus.dma_req = 1'b1;
    bus.dma_we  = 1'b1;
    bus.dma_a   = 16'h4000;
    bus.dma_wd  = 8'h22;
    #1;
    check_eq("t5_we_ph0", bus.mem_we, 1);
    check_eq("t5_o_ph0", bus.mem_o, 8'h11);
    tick();
    bus.cpu_we = 1'b0;
    #1;
    check_eq("t5_we_ph1", bus.mem_we, 0);
    tick();
    check_eq("t5_we_ph2", bus.mem_we, 1);
    check_eq("t5_o_ph2", bus.mem_o, 8'h22);
    check_eq("t5_a_ph2", bus.mem_a, 16'h4000);
    tick();
    check_eq("t5_ack", bus.dma_ack, 1);
    check_eq("t5_rd_unchanged", bus.dma_rd, 8'h77);
    bus.dma_req = 1'b0;
    bus.dma_we  = 1'b0;
    tick();
    check_eq("t5_ram4000", ram[16'h4000], 8'h22);

    // Reset in the middle of a granted transfer.
    bus.cpu_a   = 16'h0000;
    bus.dma_req = 1'b1;
    bus.dma_a   = 16'h1234;
    tick();
    tick();
    check_eq("rm_cpu_clk_pre", cpu_clk, 1);
    pin_rstn = 1'b0;
    #1;
    check_eq("rm_cpu_clk", cpu_clk, 0);
    check_eq("rm_ack", bus.dma_ack, 0);
    check_eq("rm_mem_we", bus.mem_we, 0);
    bus.dma_req = 1'b0;
    tick();
    check_eq("rm_ack_held", bus.dma_ack, 0);
    release_reset();
    for (int i = 0; i < 4; i++) begin
      check_eq("rm_ack_after", bus.dma_ack, 0);
      check_eq("rm_cpu_clk_after", cpu_clk, (ph >= 2) ? 1 : 0);
      tick();
    end

`ifdef MEM_SLOT_ARBITER_STALL_EN
    // 6: hogging steals ph0 and freezes the CPU clock.
    bus.dma_hog = 1'b1;
    bus.dma_req = 1'b1;
    bus.dma_we  = 1'b0;
    bus.dma_a   = 16'h1234;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t6_r1_ack", bus.dma_ack, (ph == 3) ? 1 : 0);
      check_eq("t6_r1_cpu_clk", cpu_clk, (ph >= 2) ? 1 : 0);
      tick();
    end
    bus.cpu_a = 16'h8000;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t6_r2_ack", bus.dma_ack, (ph == 1 || ph == 3) ? 1 : 0);
      check_eq("t6_r2_cpu_clk", cpu_clk, 0);
      check_eq("t6_r2_cpu_i", bus.cpu_i, 8'h3e);
      if (ph == 1 || ph == 3) check_eq("t6_r2_rd", bus.dma_rd, 8'h5a);
      if (ph == 3) bus.dma_hog = 1'b0;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check_eq("t6_r3_cpu_clk", cpu_clk, (ph >= 2) ? 1 : 0);
      check_eq("t6_r3_ack", bus.dma_ack, (ph == 3) ? 1 : 0);
      if (ph == 2) check_eq("t6_r3_cpu_i", bus.cpu_i, 8'ha5);
      tick();
    end
    bus.dma_hog = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_eq("t6_r5_cpu_clk", cpu_clk, 0);
    tick();
    check_eq("t6_r5_ack_ph1", bus.dma_ack, 1);
    pin_rstn = 1'b0;
    #1;
    check_eq("t6_rst_ack", bus.dma_ack, 0);
    check_eq("t6_rst_cpu_clk", cpu_clk, 0);
    bus.dma_req = 1'b0;
    bus.dma_hog = 1'b0;
    release_reset();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
